if_weight_loader: RTL and testbench

Initiator for the SNN weight-memory port (mem_addr/mem_din/mem_wen/mem_dout) exposed by the IF network and layer blocks. It accepts a valid/ready stream of weight words from the host side and writes them into one layer's weight memory. Writes run neuron-major, with the weight index as the inner loop. After the write pass it reads every written location back and compares a running checksum to detect write failures.

---
 rtl/if_weight_loader.sv | 182 ++++++++++++++++++
 tb/tb_if_weight_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_weight_loader.sv
// Weight loader for one SNN layer. It streams host weight words into the
// layer weight memory, neuron-major with the weight index as the inner loop.
// It then reads every written location back and compares the readback sum
// against the write-pass checksum.
module if_weight_loader #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int LAYER_ADDR_WIDTH  = 32,
  parameter int NEURON_ADDR_WIDTH = 28,
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int READ_LATENCY      = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [LAYER_ADDR_WIDTH-NEURON_ADDR_WIDTH-1:0]  layer_sel,
  input  logic [NEURON_ADDR_WIDTH-WEIGHT_ADDR_WIDTH-1:0] num_neurons,
  input  logic [WEIGHT_ADDR_WIDTH:0]                    num_weights,
  input  logic [WEIGHT_SIZE-1:0]                        s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [LAYER_ADDR_WIDTH-1:0]                   mem_addr,
  output logic [WEIGHT_SIZE-1:0]                        mem_din,
  output logic                                          mem_wen,
  input  logic [WEIGHT_SIZE-1:0]                        mem_dout,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic [WEIGHT_SIZE-1:0]                        checksum
);

  localparam int LW = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
  localparam int NW = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
  localparam int WW = WEIGHT_ADDR_WIDTH;

  localparam logic [NW-1:0] N_ONE  = 1;
  localparam logic [WW-1:0] WI_ONE = 1;
  localparam logic [WW:0]   W_ONE  = 1;

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, DONE} state_t;

  typedef struct packed {
    logic                        wen;
    logic [LAYER_ADDR_WIDTH-1:0] addr;
    logic [WEIGHT_SIZE-1:0]      din;
  } mem_req_t;

  state_t   state, state_nxt;
  mem_req_t req_q;

  logic [LW-1:0]          layer_q;
  logic [NW-1:0]          nn_q;
  logic [WW:0]            nw_q;
  logic [NW-1:0]          n_idx, n_nxt;
  logic [WW-1:0]          w_idx, w_nxt;
  logic [WEIGHT_SIZE-1:0] rd_sum;
  logic                   wr_last;   // final write strobe is on the bus this cycle
  logic                   w_last, n_last, all_last, hs;
  logic                   rd_issue, rd_ret;
  logic [LAYER_ADDR_WIDTH-1:0] cur_addr, nxt_addr;

  // vld_pipe[i] is set i cycles after a read address was issued. The top bit
  // marks the cycle in which mem_dout carries that location's data.
  logic [READ_LATENCY:1]  vld_pipe;

  assign w_last   = ({1'b0, w_idx} == (nw_q - W_ONE));
  assign n_last   = (n_idx == (nn_q - N_ONE));
  assign all_last = w_last && n_last;
  assign w_nxt    = w_last ? '0 : (w_idx + WI_ONE);
  assign n_nxt    = w_last ? (n_idx + N_ONE) : n_idx;
  assign cur_addr = {layer_q, n_idx, w_idx};
  assign nxt_addr = {layer_q, n_nxt, w_nxt};
  assign hs       = s_valid && s_ready;
  assign rd_issue = (state == RD_ISSUE);
  assign rd_ret   = vld_pipe[READ_LATENCY];

  assign mem_wen  = req_q.wen;
  assign mem_addr = req_q.addr;
  assign mem_din  = req_q.din;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)
                  state_nxt = (num_neurons == '0 || num_weights == '0) ? DONE : WRITE;
      WRITE:    if (wr_last) state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_ret) state_nxt = all_last ? CHECK : RD_ISSUE;
      CHECK:    state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state; s_ready closes while the final write drains
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    s_ready = (state == WRITE) && !wr_last;
    busy    = (state != IDLE) && (state != DONE);
    done    = (state == DONE);
  end

  // Read-latency tracker, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Datapath: parameter latch, index walk, memory request, sums and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      layer_q  <= '0;
      nn_q     <= '0;
      nw_q     <= '0;
      n_idx    <= '0;
      w_idx    <= '0;
      rd_sum   <= '0;
      checksum <= '0;
      err      <= 1'b0;
      wr_last  <= 1'b0;
    end else begin
      req_q.wen <= 1'b0;
      case (state)
        IDLE: if (start) begin
          layer_q  <= layer_sel;
          nn_q     <= num_neurons;
          nw_q     <= num_weights;
          n_idx    <= '0;
          w_idx    <= '0;
          rd_sum   <= '0;
          checksum <= '0;
          err      <= 1'b0;
          wr_last  <= 1'b0;
        end
        WRITE: begin
          if (wr_last) begin
            // Indices are already back at zero: preload the first read address
            wr_last    <= 1'b0;
            req_q.addr <= cur_addr;
          end else if (hs) begin
            req_q.wen  <= 1'b1;
            req_q.addr <= cur_addr;
            req_q.din  <= s_data;
            checksum   <= checksum + s_data;
            if (all_last) begin
              n_idx   <= '0;
              w_idx   <= '0;
              wr_last <= 1'b1;
            end else begin
              n_idx <= n_nxt;
              w_idx <= w_nxt;
            end
          end
        end
        RD_WAIT: if (rd_ret) begin
          rd_sum <= rd_sum + mem_dout;
          if (!all_last) begin
            n_idx      <= n_nxt;
            w_idx      <= w_nxt;
            req_q.addr <= nxt_addr;
          end
        end
        CHECK: err <= (rd_sum != checksum);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_weight_loader.sv
// Directed bench for if_weight_loader: a READ_LATENCY=1 instance plus a
// READ_LATENCY=3 instance, each backed by its own small memory model.
module tb_if_weight_loader;

  logic        clk = 1'b0;
  logic        rst, start, start3;
  logic [3:0]  layer_sel;
  logic [17:0] num_neurons;
  logic [10:0] num_weights;
  logic [31:0] s_data;
  logic        s_valid;

  logic        s_ready, mem_wen, busy, done, err;
  logic [31:0] mem_addr, mem_din, mem_dout, checksum;
  logic        s_ready3, mem_wen3, busy3, done3, err3;
  logic [31:0] mem_addr3, mem_din3, mem_dout3, checksum3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          done_cnt;
  bit          corrupt = 1'b0;

  logic [31:0] mem  [0:65535];
  logic [31:0] mem3 [0:65535];
  logic [31:0] d3a, d3b;

  always #5 clk = ~clk;

  if_weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
    .num_neurons(num_neurons), .num_weights(num_weights),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  if_weight_loader #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .layer_sel(layer_sel),
    .num_neurons(num_neurons), .num_weights(num_weights),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready3),
    .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_wen(mem_wen3), .mem_dout(mem_dout3),
    .busy(busy3), .done(done3), .err(err3), .checksum(checksum3)
  );

  function automatic logic [15:0] midx(input logic [31:0] a);
    return {a[31:28], a[11:0]};
  endfunction

  // Latency-1 memory with optional bit-0 corruption of address 0x401
  always @(posedge clk) begin
    if (mem_wen) mem[midx(mem_addr)] <= mem_din;
    mem_dout <= mem[midx(mem_addr)] ^ {31'b0, corrupt && (mem_addr == 32'h401)};
  end

  // Latency-3 memory
  always @(posedge clk) begin
    if (mem_wen3) mem3[midx(mem_addr3)] <= mem_din3;
    d3a       <= mem3[midx(mem_addr3)];
    d3b       <= d3a;
    mem_dout3 <= d3b;
  end

  // Write and done monitor for the latency-1 instance
  always @(negedge clk) begin
    if (mem_wen) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
    end
    if (done) done_cnt++;
  end

  // Start one load and stream words[] until done; dcyc = cycles after start edge
  task automatic run_load(input logic [3:0] ly, input logic [17:0] nn, input logic [10:0] nw,
                          input bit tog, input bit use3, output int dcyc);
    int k;
    bit v, hs, rdy, dn;
    wa.delete(); wd.delete(); done_cnt = 0;
    @(negedge clk);
    layer_sel = ly; num_neurons = nn; num_weights = nw;
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    k = 0; dcyc = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      rdy = use3 ? s_ready3 : s_ready;
      dn  = use3 ? done3 : done;
      if (dn) begin dcyc = cyc; break; end
      v = (k < words.size()) && (!tog || cyc[0]);
      s_valid = v;
      s_data  = v ? words[k] : 32'h0;
      hs = v && rdy;
      @(negedge clk);
      if (hs) k++;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({mem_wen, busy, done, s_ready, err, checksum, mem_addr, mem_din} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got wen=%b busy=%b done=%b rdy=%b err=%b cs=%h addr=%h, want all 0",
                         mem_wen, busy, done, s_ready, err, checksum, mem_addr);
    end
    n_checks++;
    if ({mem_wen3, busy3, done3, s_ready3, err3, checksum3, mem_addr3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_lat3: got nonzero outputs, want all 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int dcyc;
    logic [31:0] ea[6];
    ea = '{32'h000, 32'h001, 32'h002, 32'h400, 32'h401, 32'h402};
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_load(4'd0, 18'd2, 11'd3, 1'b0, 1'b0, dcyc);
    // 6 writes + drain + 6*2 reads + CHECK -> done in cycle 21
    n_checks++;
    if (dcyc !== 21) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 21", dcyc); end
    n_checks++;
    if (checksum !== 32'd21 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_checksum: got cs=%0d err=%b want cs=21 err=0", checksum, err);
    end
    n_checks++;
    if (wa.size() !== 6) begin n_fail++; $display("FAIL basic_write_count: got %0d want 6", wa.size()); end
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== ea[i] || wd[i] !== words[i]) begin
        n_fail++; $display("FAIL basic_write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                           i, wa[i], wd[i], ea[i], words[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done_pulse: got done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_cnt);
    end
  endtask

  task automatic test_layer;
    int dcyc;
    words = '{32'hDEADBEEF};
    run_load(4'd3, 18'd1, 11'd1, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (wa.size() !== 1 || wa[0] !== 32'h3000_0000 || wd[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL layer_write: got n=%0d addr=%h want 1 write at 30000000", wa.size(),
                         (wa.size() > 0) ? wa[0] : 32'hx);
    end
    n_checks++;
    if (checksum !== 32'hDEADBEEF || err !== 1'b0 || dcyc !== 6) begin
      n_fail++; $display("FAIL layer_checksum: got cs=%h err=%b done@%0d want DEADBEEF 0 6", checksum, err, dcyc);
    end
  endtask

  task automatic test_backpressure;
    int dcyc;
    logic [31:0] ea[6];
    ea = '{32'h000, 32'h001, 32'h002, 32'h400, 32'h401, 32'h402};
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_load(4'd0, 18'd2, 11'd3, 1'b1, 1'b0, dcyc);
    // handshakes in cycles 1,3,..,11 -> done in cycle 26
    n_checks++;
    if (dcyc !== 26) begin n_fail++; $display("FAIL bp_done_cycle: got %0d want 26", dcyc); end
    n_checks++;
    if (wa.size() !== 6) begin n_fail++; $display("FAIL bp_write_count: got %0d want 6", wa.size()); end
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== ea[i] || wd[i] !== words[i]) begin
        n_fail++; $display("FAIL bp_write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                           i, wa[i], wd[i], ea[i], words[i]);
      end
    end
    n_checks++;
    if (checksum !== 32'd21 || err !== 1'b0) begin
      n_fail++; $display("FAIL bp_checksum: got cs=%0d err=%b want 21 0", checksum, err);
    end
  endtask

  task automatic test_corruption;
    int dcyc;
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    corrupt = 1'b1;
    run_load(4'd0, 18'd2, 11'd3, 1'b0, 1'b0, dcyc);
    corrupt = 1'b0;
    n_checks++;
    if (err !== 1'b1 || checksum !== 32'd21) begin
      n_fail++; $display("FAIL corrupt_err: got err=%b cs=%0d want err=1 cs=21", err, checksum);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL corrupt_sticky: got err=%b want 1", err); end
    words.delete();
    run_load(4'd0, 18'd2, 11'd0, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (err !== 1'b0 || checksum !== 32'd0) begin
      n_fail++; $display("FAIL corrupt_clear: got err=%b cs=%0d want 0 0", err, checksum);
    end
  endtask

  task automatic test_zero_weights;
    int dcyc;
    words = '{32'd9};
    run_load(4'd1, 18'd4, 11'd0, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (dcyc !== 1 || wa.size() !== 0) begin
      n_fail++; $display("FAIL zero_weights: got done@%0d writes=%0d want done@1 writes=0", dcyc, wa.size());
    end
    words.delete();
    run_load(4'd1, 18'd0, 11'd5, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (dcyc !== 1 || wa.size() !== 0) begin
      n_fail++; $display("FAIL zero_neurons: got done@%0d writes=%0d want done@1 writes=0", dcyc, wa.size());
    end
  endtask

  task automatic test_checksum_wrap;
    int dcyc;
    words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_load(4'd0, 18'd1, 11'd2, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (checksum !== 32'hFFFF_FFFE || err !== 1'b0) begin
      n_fail++; $display("FAIL checksum_wrap: got cs=%h err=%b want FFFFFFFE 0", checksum, err);
    end
    n_checks++;
    if (wa.size() !== 2 || wa[0] !== 32'h000 || wa[1] !== 32'h001) begin
      n_fail++; $display("FAIL wrap_addrs: got n=%0d want 2 writes at 000,001", wa.size());
    end
  endtask

  task automatic test_read_latency;
    int dcyc;
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_load(4'd0, 18'd2, 11'd3, 1'b0, 1'b1, dcyc);
    // 6 writes + drain + 24 readback cycles + CHECK -> done in cycle 33
    n_checks++;
    if (dcyc !== 33) begin n_fail++; $display("FAIL lat3_done_cycle: got %0d want 33", dcyc); end
    n_checks++;
    if (checksum3 !== 32'd21 || err3 !== 1'b0) begin
      n_fail++; $display("FAIL lat3_checksum: got cs=%0d err=%b want 21 0", checksum3, err3);
    end
  endtask

  task automatic test_reset_mid_write;
    int dcyc;
    @(negedge clk);
    layer_sel = 4'd0; num_neurons = 18'd2; num_weights = 11'd3; start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 32'd1;
    @(negedge clk); s_data = 32'd2;
    @(negedge clk); s_valid = 1'b0;
    n_checks++;
    if (mem_wen !== 1'b1 || checksum !== 32'd3) begin
      n_fail++; $display("FAIL midrst_pre: got wen=%b cs=%0d want 1 3", mem_wen, checksum);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_wen, busy, done, s_ready, err, checksum, mem_addr, mem_din} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got wen=%b busy=%b done=%b rdy=%b cs=%h addr=%h, want all 0",
                         mem_wen, busy, done, s_ready, checksum, mem_addr);
    end
    @(negedge clk); rst = 1'b0;
    words = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_load(4'd0, 18'd2, 11'd3, 1'b0, 1'b0, dcyc);
    n_checks++;
    if (dcyc !== 21 || checksum !== 32'd21 || err !== 1'b0 || wa.size() !== 6) begin
      n_fail++; $display("FAIL midrst_reload: got done@%0d cs=%0d err=%b writes=%0d want 21 21 0 6",
                         dcyc, checksum, err, wa.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; s_valid = 1'b0; s_data = '0;
    layer_sel = '0; num_neurons = '0; num_weights = '0; done_cnt = 0;
    test_reset();
    test_basic();
    test_layer();
    test_backpressure();
    test_corruption();
    test_zero_weights();
    test_checksum_wrap();
    test_read_latency();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
